// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor with valid/ready handshakes on both sides.
// Define SERIAL_ADD_SUB_OVF_EN to enable the overflow flag V; otherwise V is tied low.
module serial_add_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_nxt;
   logic             last_bit;
   logic             done;

   assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign last_bit  = (cnt == CW'(WIDTH - 1));

   // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= A;
                  b_sh  <= sub ? ~B : B;
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= {sum_bit, sum_sh[WIDTH-1:1]};
               carry  <= carry_nxt;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done      = (state == DONE);
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = done;
   assign S         = done ? sum_sh : '0;
   assign Cout      = done & carry;

`ifdef SERIAL_ADD_SUB_OVF_EN
   logic cin_msb;

   // Capture the carry entering the MSB while the MSB itself is being added.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cin_msb <= 1'b0;
      end else if (state == RUN && last_bit) begin
         cin_msb <= carry;
      end
   end

   assign V = done & (cin_msb ^ carry);
`else
   assign V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed table, handshake corner cases and
// randomized operations scored against an arithmetic reference model.
module tb_serial_add_sub;

   localparam int WIDTH = 4;
`ifdef SERIAL_ADD_SUB_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             V;
   logic             busy;

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             v;
   } vec_t;

   serial_add_sub #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .Cout      (Cout),
      .V         (V),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range check for overflow.
   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s_in,
                        output logic [WIDTH-1:0] s, output logic c, output logic v);
      int unsigned bv;
      int unsigned tot;
      int sa;
      int sb;
      int r;
      bv  = s_in ? ((~32'(b)) & ((1 << WIDTH) - 1)) : 32'(b);
      tot = 32'(a) + bv + 32'(s_in);
      s   = tot[WIDTH-1:0];
      c   = tot[WIDTH];
      sa  = $signed(a);
      sb  = $signed(b);
      r   = s_in ? (sa - sb) : (sa + sb);
      v   = OVF && ((r > (2 ** (WIDTH - 1)) - 1) || (r < -(2 ** (WIDTH - 1))));
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s_in);
      int edges;
      @(negedge clk);
      compare("in_ready_idle", 32'(in_ready), 1);
      A        = a;
      B        = b;
      sub      = s_in;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      A         = WIDTH'($urandom);
      B         = WIDTH'($urandom);
      sub       = 1'($urandom);
      out_ready = 1'($urandom);
      compare("busy_run", 32'(busy), 1);
      compare("in_ready_run", 32'(in_ready), 0);
      compare("S_zero_run", 32'(S), 0);
      edges = 0;
      while (!out_valid && edges < 3 * WIDTH) begin
         @(posedge clk);
         #1;
         edges++;
      end
      compare("latency", edges, WIDTH);
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] s,
                              input logic c, input logic v);
      compare({name, "_S"}, 32'(S), 32'(s));
      compare({name, "_Cout"}, 32'(Cout), 32'(c));
      compare({name, "_V"}, 32'(V), 32'(v));
   endtask

   task automatic handoff();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      compare("handoff_out_valid", 32'(out_valid), 0);
      compare("handoff_in_ready", 32'(in_ready), 1);
      compare("handoff_S", 32'(S), 0);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t             vecs[7];
      logic [WIDTH-1:0] es;
      logic             ec;
      logic             ev;
      logic [WIDTH-1:0] hs;
      logic             hc;
      logic             hv;
      int               accepts;
      logic             prev_busy;

      vecs[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, OVF};
      vecs[1] = '{4'b1101, 4'b1011, 1'b0, 4'b1000, 1'b1, 1'b0};
      vecs[2] = '{4'b1000, 4'b0010, 1'b1, 4'b0110, 1'b1, OVF};
      vecs[3] = '{4'b1100, 4'b1110, 1'b1, 4'b1110, 1'b0, 1'b0};
      vecs[4] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, OVF};
      vecs[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[6] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      sub       = 1'b0;
      #2;
      compare("rst_in_ready", 32'(in_ready), 1);
      compare("rst_out_valid", 32'(out_valid), 0);
      compare("rst_busy", 32'(busy), 0);
      compare("rst_S", 32'(S), 0);
      compare("rst_Cout", 32'(Cout), 0);
      compare("rst_V", 32'(V), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub);
         checkOutput($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].v);
         handoff();
      end

      // Backpressure: result must hold while out_ready is low and new offers are ignored.
      applyStimulus(4'b0011, 4'b0101, 1'b0);
      out_ready = 1'b0;
      model(4'b0011, 4'b0101, 1'b0, hs, hc, hv);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         out_ready = 1'b0;
         A         = WIDTH'($urandom);
         B         = WIDTH'($urandom);
         sub       = 1'($urandom);
         @(posedge clk);
         #1;
         compare("bp_out_valid", 32'(out_valid), 1);
         compare("bp_in_ready", 32'(in_ready), 0);
         checkOutput("bp", hs, hc, hv);
      end
      handoff();
      compare("bp_busy_after", 32'(busy), 0);

      // Reset two bits into RUN aborts the operation asynchronously.
      @(negedge clk);
      A        = 4'b0110;
      B        = 4'b0111;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      compare("arst_in_ready", 32'(in_ready), 1);
      compare("arst_busy", 32'(busy), 0);
      compare("arst_out_valid", 32'(out_valid), 0);
      checkOutput("arst", '0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      compare("arst_no_spurious", 32'(busy), 0);
      applyStimulus(4'b0011, 4'b0101, 1'b0);
      checkOutput("after_rst", 4'b1000, 1'b0, OVF);
      handoff();

      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         logic             rs;
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rs, es, ec, ev);
         applyStimulus(ra, rb, rs);
         checkOutput($sformatf("rand%0d", i), es, ec, ev);
         handoff();
      end

      // Back-to-back throughput with both sides always willing: one accept per WIDTH+2 edges.
      @(negedge clk);
      A         = 4'b0011;
      B         = 4'b0101;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      accepts   = 0;
      prev_busy = busy;
      for (int i = 0; i < 5 * (WIDTH + 2); i++) begin
         @(posedge clk);
         #1;
         if (busy && !prev_busy) accepts++;
         prev_busy = busy;
      end
      compare("throughput_accepts", accepts, 5);
      in_valid = 1'b0;
      repeat (2 * WIDTH) @(posedge clk);
      #1;
      compare("final_idle", 32'(in_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
